// File: rtl/audio_pdm_output_if.sv
// Sample stream handshake between the mixer and the PDM sink.
// master drives in_sample/in_valid; slave returns in_ready.
interface audio_pdm_output_if #(
  parameter int BITDEPTH = 12
);
  logic [BITDEPTH-1:0] in_sample;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_sample,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_sample,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/audio_pdm_output.sv
// Audio sink: sample FIFO, sample-rate divider, 1st-order PDM.
// Ports: clk, rst (sync, high), enable, in_if (sample handshake),
//   sample_tick, underrun, underrun_cnt, fifo_level, pdm_out.
module audio_pdm_output #(
  parameter int BITDEPTH   = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 1024,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  audio_pdm_output_if.slave in_if,
  output logic          sample_tick,
  output logic          underrun,
  output logic [7:0]    underrun_cnt,
  output logic [LW-1:0] fifo_level,
  output logic          pdm_out
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [BITDEPTH-1:0] MID =
    BITDEPTH'(1) << (BITDEPTH - 1);

  logic [BITDEPTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_q, wr_d;
  logic [PW-1:0]       rd_q, rd_d;
  logic [LW-1:0]       level_q, level_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic [7:0]          ucnt_q, ucnt_d;
  logic [BITDEPTH-1:0] cur_q, cur_d;
  logic [BITDEPTH-1:0] acc_q, acc_d;
  logic                pdm_q, pdm_d;

  logic                full, empty;
  logic                push, pop;
  logic                at_end;
  logic [BITDEPTH:0]   sum;

  always_comb begin
    full    = level_q == LW'(FIFO_DEPTH);
    empty   = level_q == '0;
    push    = in_if.in_valid && !full;
    // tick_q is the visible sample_tick; the pop rides on it
    pop     = tick_q && !empty;
    at_end  = cnt_q == CW'(SAMPLE_DIV - 1);

    cnt_d   = '0;
    if (enable && !at_end) cnt_d = cnt_q + CW'(1);
    tick_d  = enable && at_end;

    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    level_d = level_q + LW'(push) - LW'(pop);

    ucnt_d  = ucnt_q;
    if (tick_q && empty && ucnt_q != 8'hFF)
      ucnt_d = ucnt_q + 8'd1;

    cur_d   = pop ? mem_q[rd_q] : cur_q;

    // carry out of the accumulator is the PDM bit
    sum     = {1'b0, acc_q} + {1'b0, cur_q};
    acc_d   = sum[BITDEPTH-1:0];
    pdm_d   = sum[BITDEPTH];
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_if.in_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      ucnt_q  <= '0;
      cur_q   <= MID;
      acc_q   <= '0;
      pdm_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      ucnt_q  <= ucnt_d;
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      pdm_q   <= pdm_d;
    end
  end

  assign in_if.in_ready = !full;
  assign sample_tick    = tick_q;
  assign underrun       = tick_q && empty;
  assign underrun_cnt   = ucnt_q;
  assign fifo_level     = level_q;
  assign pdm_out        = pdm_q;

endmodule

// File: tb/tb_audio_pdm_output.sv
// Bench for audio_pdm_output: table vectors, corner sequences,
// random traffic against a queue/arithmetic reference model.
module tb_audio_pdm_output;
  localparam int BD  = 12;
  localparam int FD  = 4;
  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       sample_tick;
  logic       underrun;
  logic [7:0] underrun_cnt;
  logic [2:0] fifo_level;
  logic       pdm_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  audio_pdm_output_if #(.BITDEPTH(BD)) bus ();

  audio_pdm_output #(
    .BITDEPTH(BD),
    .FIFO_DEPTH(FD),
    .SAMPLE_DIV(DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .in_if(bus),
    .sample_tick(sample_tick),
    .underrun(underrun),
    .underrun_cnt(underrun_cnt),
    .fifo_level(fifo_level),
    .pdm_out(pdm_out)
  );

  // reference model
  int     mq[$];
  int     m_run;
  bit     m_tick;
  int     m_ucnt;
  int     m_cur;
  longint m_total;
  bit     m_pdm;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  pu, po;
    longint prev;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      m_run = 0;
      m_tick = 0;
      m_ucnt = 0;
      m_cur = 1 << (BD - 1);
      m_total = 0;
      m_pdm = 0;
    end else begin
      pu = bus.in_valid && (sz < FD);
      po = m_tick && (sz > 0);
      if (m_tick && sz == 0 && m_ucnt < 255) m_ucnt++;
      // ones so far = floor(sum of applied samples / 2**BD)
      prev = m_total;
      m_total = m_total + longint'(m_cur);
      m_pdm = (m_total >> BD) != (prev >> BD);
      if (po) m_cur = mq.pop_front();
      if (pu) mq.push_back(int'(bus.in_sample));
      // tick follows every DIV-th consecutive enabled cycle
      if (enable) m_run++;
      else m_run = 0;
      m_tick = enable && (m_run % DIV == 0);
    end
  endtask

  task automatic check_all();
    chk("level", fifo_level, mq.size());
    chk("ready", bus.in_ready, mq.size() < FD);
    chk("tick", sample_tick, m_tick);
    chk("underrun", underrun, m_tick && mq.size() == 0);
    chk("ucnt", underrun_cnt, m_ucnt);
    chk("pdm", pdm_out, m_pdm);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_tick(input string nm, input int budget);
    int n;
    n = 0;
    while (!sample_tick && n < budget) begin
      cyc();
      n++;
    end
    chk({nm, "_tick_timeout"}, sample_tick, 1);
  endtask

  typedef struct {
    logic          v;
    logic [BD-1:0] s;
    int            lvl;
    logic          rdy;
  } vec_t;

  vec_t tab[6];

  initial begin
    int ones;
    int bad;

    tab[0] = '{1'b1, 12'h111, 1, 1'b1};
    tab[1] = '{1'b1, 12'h222, 2, 1'b1};
    tab[2] = '{1'b1, 12'h333, 3, 1'b1};
    tab[3] = '{1'b1, 12'h444, 4, 1'b0};
    tab[4] = '{1'b1, 12'h5A5, 4, 1'b0};
    tab[5] = '{1'b1, 12'h5A5, 4, 1'b0};

    rst = 1'b1;
    enable = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_pdm", pdm_out, 0);
    chk("rst_ucnt", underrun_cnt, 0);

    // 1: idle midscale
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      cyc();
      if (pdm_out != (i % 2 == 1)) bad++;
    end
    chk("mid_alt_errors", bad, 0);
    chk("idle_level", fifo_level, 0);
    chk("idle_ucnt", underrun_cnt, 0);

    // 2: fill with no enable, 5th held off
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = tab[i].v;
      bus.in_sample = tab[i].s;
      cyc();
      chk($sformatf("tab_level%0d", i), fifo_level, tab[i].lvl);
      chk($sformatf("tab_ready%0d", i), bus.in_ready, tab[i].rdy);
    end
    enable = 1'b1;
    wait_tick("held", DIV + 4);
    cyc();
    chk("held_pop_level", fifo_level, 3);
    cyc();
    chk("held_push_level", fifo_level, 4);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8 * DIV && fifo_level != 0; i++) cyc();
    chk("drain_level", fifo_level, 0);

    // 3: ordered pops, zero sample period
    enable = 1'b0;
    cyc();
    bus.in_valid = 1'b1;
    bus.in_sample = 12'h000;
    cyc();
    bus.in_sample = 12'hFFF;
    cyc();
    bus.in_sample = 12'h800;
    cyc();
    bus.in_valid = 1'b0;
    chk("p3_level", fifo_level, 3);
    enable = 1'b1;
    wait_tick("p3a", DIV + 4);
    cyc();
    chk("p3_level_a", fifo_level, 2);
    ones = 0;
    for (int i = 0; i < DIV; i++) begin
      cyc();
      ones += int'(pdm_out);
    end
    chk("zero_period_ones", ones, 0);
    chk("p3_level_b", fifo_level, 1);
    wait_tick("p3c", DIV + 4);
    cyc();
    chk("p3_level_c", fifo_level, 0);

    // 4: underruns
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_tick("und", DIV + 4);
      chk("und_pulse", underrun, 1);
      cyc();
    end
    chk("ucnt3", underrun_cnt, 3);

    // 5: saturation
    for (int i = 0; i < 300; i++) begin
      wait_tick("sat", DIV + 4);
      cyc();
    end
    chk("ucnt_sat", underrun_cnt, 255);

    // 6: density of 0x400
    bus.in_valid = 1'b1;
    bus.in_sample = 12'h400;
    cyc();
    bus.in_valid = 1'b0;
    wait_tick("dens", DIV + 4);
    cyc();
    enable = 1'b0;
    cyc();
    cyc();
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      cyc();
      ones += int'(pdm_out);
    end
    chk("density_0x400", ones, 1024);

    // 7: reset mid-stream
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_sample = 12'(i * 700 + 5);
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("p7_level", fifo_level, 3);
    rst = 1'b1;
    cyc();
    chk("p7_rst_level", fifo_level, 0);
    chk("p7_rst_ready", bus.in_ready, 1);
    chk("p7_rst_pdm", pdm_out, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("p7_mid", pdm_out, i % 2);
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom % 8) != 0;
      bus.in_valid = ($urandom % 12) == 0;
      bus.in_sample = 12'($urandom);
      rst = ($urandom % 600) == 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
